// File: rtl/edge_cap_pkg.sv
// rtl/edge_cap_pkg.sv - shared types and helpers for the edge frame capture block
//
// Purpose : capture FSM state encoding and the pixel-count to byte-count
//           helper used to size the frame buffer.
// Ports   : none (package).

package edge_cap_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } cap_state_t;

  // One bit per pixel, packed eight to a byte, with the last byte rounded up.
  function automatic int nbytes_of(input int npix);
    return (npix + 7) / 8;
  endfunction

endpackage

// File: rtl/edge_cap_ram.sv
// rtl/edge_cap_ram.sv - simple dual-port byte RAM holding one binarized frame
//
// Purpose : frame buffer for packed edge bits. One write port, one read port
//           with a registered output (one cycle read latency), written so
//           that it maps onto a block RAM.
// Ports   : clk            clock
//           we/waddr/wdata write strobe, address, byte
//           re/raddr       read strobe, address
//           rdata          registered read data, valid the cycle after re

module edge_cap_ram #(
  parameter int DEPTH = 5100,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/edge_frame_capture.sv
// rtl/edge_frame_capture.sv - binarize one edge-filtered frame and stream it out as packed bytes
//
// Purpose : on an arm request, waits for the next frame start (vsync rising
//           edge), thresholds NPIX valid pixels to one bit each, packs them
//           MSB-first into a byte RAM, then streams the NBYTES bytes to the
//           host link with a valid/ready handshake.
// Ports   : clk, rst                   clock, synchronous active-high reset
//           i_start                    one-cycle arm request (IDLE only)
//           i_vsync, i_hsync, i_de     video timing (i_hsync unused)
//           i_r_data                   edge pixel
//           o_tx_data, o_tx_valid      byte stream to host
//           i_tx_ready                 host accepts byte
//           o_busy                     high whenever not IDLE
//           o_frame_done               pulse after the last byte transfers
//           o_short_frame              pulse when a new vsync truncates a frame

module edge_frame_capture
  import edge_cap_pkg::*;
#(
  parameter int H_RES  = 170,
  parameter int V_RES  = 240,
  parameter int BIN_TH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_vsync,
  input  logic       i_hsync,
  input  logic       i_de,
  input  logic [7:0] i_r_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_short_frame
);

  localparam int NPIX   = H_RES * V_RES;
  localparam int NBYTES = nbytes_of(NPIX);
  localparam int PCW    = $clog2(NPIX + 1);
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int RAW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [PCW-1:0] LAST_PIX  = PCW'(NPIX - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [BCW-1:0] NBYTES_C  = BCW'(NBYTES);
  localparam logic [7:0]     TH        = 8'(BIN_TH);

  // Line sync carries no information for a whole-frame bitmap.
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  cap_state_t state;

  // ---------------------------------------------------------------------
  // Capture path
  // ---------------------------------------------------------------------
  logic           vs_prev;
  logic           vs_rise;
  logic [PCW-1:0] pix_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     shift;
  logic           pix_bit;
  logic [7:0]     packed_bits;
  logic [7:0]     wr_data;
  logic           group_end;
  logic           last_pix;
  logic           cap_px;
  logic           wr_en;

  assign vs_rise     = i_vsync & ~vs_prev;
  assign pix_bit     = (i_r_data >= TH);
  assign packed_bits = {shift[6:0], pix_bit};
  assign group_end   = (pix_cnt[2:0] == 3'd7);
  assign last_pix    = (pix_cnt == LAST_PIX);

  // Left-justify a partial final group: the stale bits of the previous byte
  // sitting above the current group fall off the top, and the unused LSBs
  // fill with zeros. For a full group the shift amount is zero.
  assign wr_data = packed_bits << (3'd7 - pix_cnt[2:0]);

  // A pixel arriving together with a frame-start edge belongs to neither
  // frame; counting starts with the cycle after the edge.
  assign cap_px = (state == ST_CAPTURE) && !vs_rise && i_de;
  assign wr_en  = cap_px && (group_end || last_pix);

  // ---------------------------------------------------------------------
  // Readout path
  // ---------------------------------------------------------------------
  // The RAM output is one cycle late, so a read issued while the output
  // register is stalled needs somewhere to land: a one-entry skid register.
  // A read is only issued if output + skid can absorb everything already
  // held or in flight, which keeps the stream at one byte per cycle when
  // the host never stalls.
  logic [BCW-1:0] rd_addr;
  logic [BCW-1:0] tx_cnt;
  logic           rd_pend;
  logic           skid_valid;
  logic [7:0]     skid_data;
  logic [7:0]     ram_rdata;
  logic           xfer;
  logic           out_free;
  logic [1:0]     occ;
  logic [1:0]     fill_after;
  logic           rd_issue;

  assign xfer       = o_tx_valid & i_tx_ready;
  assign out_free   = !o_tx_valid || xfer;
  assign occ        = {1'b0, o_tx_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
  assign fill_after = occ - {1'b0, xfer};
  assign rd_issue   = (state == ST_READOUT) && (rd_addr != NBYTES_C) && (fill_after < 2'd2);

  edge_cap_ram #(
    .DEPTH (NBYTES),
    .AW    (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (byte_cnt[RAW-1:0]),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rd_addr[RAW-1:0]),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      vs_prev       <= 1'b0;
      pix_cnt       <= '0;
      byte_cnt      <= '0;
      shift         <= '0;
      rd_addr       <= '0;
      tx_cnt        <= '0;
      rd_pend       <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      o_tx_data     <= '0;
      o_tx_valid    <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_short_frame <= 1'b0;
    end else begin
      vs_prev       <= i_vsync;
      o_frame_done  <= 1'b0;
      o_short_frame <= 1'b0;
      rd_pend       <= rd_issue;
      if (rd_issue) begin
        rd_addr <= rd_addr + BCW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_WAIT_VS;
            o_busy <= 1'b1;
          end
        end

        ST_WAIT_VS: begin
          if (vs_rise) begin
            state    <= ST_CAPTURE;
            pix_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
          end
        end

        ST_CAPTURE: begin
          if (vs_rise) begin
            // Frame cut short: discard what was gathered and treat this
            // edge as the start of a fresh frame.
            o_short_frame <= 1'b1;
            pix_cnt       <= '0;
            byte_cnt      <= '0;
            shift         <= '0;
          end else if (i_de) begin
            shift   <= packed_bits;
            pix_cnt <= pix_cnt + PCW'(1);
            if (wr_en) begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
            if (last_pix) begin
              state      <= ST_READOUT;
              rd_addr    <= '0;
              tx_cnt     <= '0;
              skid_valid <= 1'b0;
            end
          end
        end

        ST_READOUT: begin
          // Output register refills in order: skid first, then RAM data.
          if (out_free) begin
            if (skid_valid) begin
              o_tx_data  <= skid_data;
              o_tx_valid <= 1'b1;
              skid_valid <= rd_pend;
              if (rd_pend) begin
                skid_data <= ram_rdata;
              end
            end else if (rd_pend) begin
              o_tx_data  <= ram_rdata;
              o_tx_valid <= 1'b1;
            end else begin
              o_tx_valid <= 1'b0;
            end
          end else if (rd_pend) begin
            skid_data  <= ram_rdata;
            skid_valid <= 1'b1;
          end

          if (xfer) begin
            tx_cnt <= tx_cnt + BCW'(1);
            if (tx_cnt == LAST_BYTE) begin
              state        <= ST_IDLE;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
              o_tx_valid   <= 1'b0;
              skid_valid   <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_frame_capture.sv
// tb/tb_edge_frame_capture.sv - directed self-checking bench for edge_frame_capture
//
// Purpose : three instances (default 170x240, 40x40, 5x3) driven by one
//           linear directed sequence; expected bytes come from constants or
//           a small bit-packing model of the pixel patterns.
// Ports   : none (top-level bench).

module tb_edge_frame_capture;

  localparam int NI = 3;

  logic       clk;
  logic       rst;
  logic       start      [NI];
  logic       vsync      [NI];
  logic       hsync      [NI];
  logic       de         [NI];
  logic [7:0] rdat       [NI];
  logic       ready      [NI];
  logic [7:0] tx_data    [NI];
  logic       tx_valid   [NI];
  logic       busy       [NI];
  logic       frame_done [NI];
  logic       short_frame[NI];

  int checks   = 0;
  int failures = 0;

  // Read-task results.
  logic [7:0] got_q[$];
  logic [7:0] seq_a[$];
  int         done_pulses;
  int         stall_bad;
  int         timed_out;
  int         first_xfer;
  int         last_xfer;
  logic       fd_after;
  logic       v_after;
  logic       b_after;

  edge_frame_capture u_def (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_vsync(vsync[0]), .i_hsync(hsync[0]),
    .i_de(de[0]), .i_r_data(rdat[0]), .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]),
    .i_tx_ready(ready[0]), .o_busy(busy[0]), .o_frame_done(frame_done[0]),
    .o_short_frame(short_frame[0])
  );

  edge_frame_capture #(.H_RES(40), .V_RES(40), .BIN_TH(128)) u_med (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_vsync(vsync[1]), .i_hsync(hsync[1]),
    .i_de(de[1]), .i_r_data(rdat[1]), .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]),
    .i_tx_ready(ready[1]), .o_busy(busy[1]), .o_frame_done(frame_done[1]),
    .o_short_frame(short_frame[1])
  );

  edge_frame_capture #(.H_RES(5), .V_RES(3), .BIN_TH(128)) u_sml (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_vsync(vsync[2]), .i_hsync(hsync[2]),
    .i_de(de[2]), .i_r_data(rdat[2]), .o_tx_data(tx_data[2]), .o_tx_valid(tx_valid[2]),
    .i_tx_ready(ready[2]), .o_busy(busy[2]), .o_frame_done(frame_done[2]),
    .o_short_frame(short_frame[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel patterns: 0 alternating FF/00, 1 all FF, 2 pseudo-random, 3 directed.
  function automatic logic [7:0] pix_val(input int mode, input int idx);
    logic [7:0] v;
    case (mode)
      0: v = (idx % 2 == 0) ? 8'hFF : 8'h00;
      1: v = 8'hFF;
      2: v = 8'(idx * 29 + (idx / 7) * 13);
      default: begin
        if (idx == 0)      v = 8'h80;
        else if (idx < 8)  v = 8'h00;
        else if (idx < 14) v = (idx % 2 == 0) ? 8'h7F : 8'h80;
        else               v = 8'hFF;
      end
    endcase
    return v;
  endfunction

  function automatic logic [7:0] exp_byte(input int mode, input int i, input int npix);
    logic [7:0] b;
    b = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if ((8 * i + j) < npix && pix_val(mode, 8 * i + j) >= 8'd128) b[7 - j] = 1'b1;
    end
    return b;
  endfunction

  task automatic arm(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic vs_start(input int k);
    vsync[k] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vsync[k] = 1'b0;
    @(negedge clk);
  endtask

  // Drives n valid pixels; with gaps, every eighth cycle has de low and
  // carries the inverted pixel so a mis-sampled gap corrupts the frame.
  task automatic send_frame(input int k, input int n, input int mode, input bit gaps);
    int idx;
    int c;
    idx = 0;
    c = 0;
    while (idx < n) begin
      if (gaps && (c % 8) == 5) begin
        de[k]   = 1'b0;
        rdat[k] = ~pix_val(mode, idx);
      end else begin
        de[k]   = 1'b1;
        rdat[k] = pix_val(mode, idx);
        idx++;
      end
      hsync[k] = ((c % 16) == 0);
      c++;
      @(negedge clk);
    end
    de[k]    = 1'b0;
    hsync[k] = 1'b0;
  endtask

  task automatic read_frame(input int k, input int nbytes, input bit rnd);
    int   cyc;
    logic pv;
    logic pr;
    logic [7:0] pd;
    got_q.delete();
    done_pulses = 0;
    stall_bad   = 0;
    timed_out   = 0;
    first_xfer  = -1;
    last_xfer   = -1;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    cyc = 0;
    while (got_q.size() < nbytes && cyc < 40000) begin
      ready[k] = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (pv && !pr && (tx_valid[k] !== 1'b1 || tx_data[k] !== pd)) stall_bad++;
      if (frame_done[k] === 1'b1) done_pulses++;
      if (tx_valid[k] === 1'b1 && ready[k]) begin
        got_q.push_back(tx_data[k]);
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      pv = tx_valid[k];
      pr = ready[k];
      pd = tx_data[k];
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 40000) timed_out = 1;
    ready[k] = 1'b0;
    fd_after = frame_done[k];
    v_after  = tx_valid[k];
    b_after  = busy[k];
    if (frame_done[k] === 1'b1) done_pulses++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done[k] === 1'b1) done_pulses++;
    end
  endtask

  task automatic check_read(input string pfx, input int nbytes);
    check({pfx, "_timeout"}, timed_out, 0);
    check({pfx, "_count"}, got_q.size(), nbytes);
    check({pfx, "_stall_hold"}, stall_bad, 0);
    check({pfx, "_done_after_last"}, fd_after, 1'b1);
    check({pfx, "_done_once"}, done_pulses, 1);
    check({pfx, "_valid_low_after"}, v_after, 1'b0);
    check({pfx, "_busy_low_after"}, b_after, 1'b0);
  endtask

  task automatic check_model(input string pfx, input int mode, input int npix);
    int mism;
    mism = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== exp_byte(mode, i, npix)) mism++;
    end
    check({pfx, "_bytes"}, mism, 0);
  endtask

  initial begin
    int mism;
    int seen_bad;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0; vsync[k] = 1'b0; hsync[k] = 1'b0;
      de[k] = 1'b0; rdat[k] = 8'h00; ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_tx_data", tx_data[0], 8'h00);
    check("rst_tx_valid", tx_valid[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_frame_done", frame_done[0], 1'b0);
    check("rst_short_frame", short_frame[0], 1'b0);
    check("rst_busy_small", busy[2], 1'b0);

    // Threshold boundary 0x7F/0x80 and partial last byte; start ignored in READOUT.
    arm(2);
    check("arm_busy", busy[2], 1'b1);
    vs_start(2);
    send_frame(2, 15, 3, 1'b1);
    de[2] = 1'b1; rdat[2] = 8'hFF;
    repeat (3) @(negedge clk);
    de[2] = 1'b0;
    check("readout_valid_held", tx_valid[2], 1'b1);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    read_frame(2, 2, 1'b0);
    check_read("thr", 2);
    check("thr_byte0", got_q.size() > 0 ? got_q[0] : 8'hXX, 8'h80);
    check("thr_byte1", got_q.size() > 1 ? got_q[1] : 8'hXX, 8'h56);
    check("start_in_readout_ignored", busy[2], 1'b0);

    // 5x3 all white -> FF, FE.
    arm(2);
    vs_start(2);
    send_frame(2, 15, 1, 1'b0);
    read_frame(2, 2, 1'b0);
    check_read("small", 2);
    check("small_byte0", got_q.size() > 0 ? got_q[0] : 8'hXX, 8'hFF);
    check("small_byte1", got_q.size() > 1 ? got_q[1] : 8'hXX, 8'hFE);

    // 40x40 pseudo-random frame, ready held high: model match, full rate.
    arm(1);
    vs_start(1);
    send_frame(1, 1600, 2, 1'b1);
    read_frame(1, 200, 1'b0);
    check_read("med_fast", 200);
    check_model("med_fast", 2, 1600);
    check("med_fast_rate", last_xfer - first_xfer, 199);
    seq_a = got_q;

    // Same frame with ready at ~30% duty: identical sequence.
    arm(1);
    vs_start(1);
    send_frame(1, 1600, 2, 1'b1);
    read_frame(1, 200, 1'b1);
    check_read("med_slow", 200);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < seq_a.size(); i++) begin
      if (got_q[i] !== seq_a[i]) mism++;
    end
    check("med_slow_vs_fast", mism, 0);

    // Reset held two cycles in the middle of READOUT.
    arm(1);
    vs_start(1);
    send_frame(1, 1600, 0, 1'b0);
    ready[1] = 1'b1;
    repeat (50) @(negedge clk);
    check("pre_rst_streaming", tx_valid[1], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", tx_valid[1], 1'b0);
    check("mid_rst_busy", busy[1], 1'b0);
    seen_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid[1] !== 1'b0 || frame_done[1] !== 1'b0 || busy[1] !== 1'b0) seen_bad++;
      @(negedge clk);
    end
    check("mid_rst_quiet", seen_bad, 0);
    ready[1] = 1'b0;

    // Video activity while IDLE is ignored.
    vs_start(1);
    send_frame(1, 40, 1, 1'b0);
    check("idle_ignores_video", busy[1], 1'b0);
    check("idle_no_output", tx_valid[1], 1'b0);

    // Truncated frame after 1000 pixels, then a full frame.
    arm(1);
    vs_start(1);
    send_frame(1, 1000, 1, 1'b0);
    vsync[1] = 1'b1;
    @(negedge clk);
    check("short_pulse", short_frame[1], 1'b1);
    @(negedge clk);
    check("short_pulse_one_cycle", short_frame[1], 1'b0);
    vsync[1] = 1'b0;
    @(negedge clk);
    check("short_still_capturing", busy[1], 1'b1);
    send_frame(1, 1600, 2, 1'b1);
    read_frame(1, 200, 1'b0);
    check_read("after_short", 200);
    check_model("after_short", 2, 1600);

    // Default geometry, alternating FF/00 -> 5100 bytes of AA.
    arm(0);
    vs_start(0);
    send_frame(0, 40800, 0, 1'b1);
    read_frame(0, 5100, 1'b0);
    check_read("full", 5100);
    mism = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== 8'hAA) mism++;
    end
    check("full_bytes_aa", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_frame_capture.md
EDGE_FRAME_CAPTURE -- requirements
Module: edge_frame_capture

Interface
REQ-001 Parameter H_RES, default 170, active pixels per line.
REQ-002 Parameter V_RES, default 240, active lines per frame.
REQ-003 Parameter BIN_TH, default 128, binarization threshold on i_r_data.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  one-cycle arm request.
REQ-007 i_vsync  in  1  frame sync from edge filter; active-high.
REQ-008 i_hsync  in  1  line sync; accepted, unused.
REQ-009 i_de  in  1  pixel valid.
REQ-010 i_r_data  in  8  edge pixel (0x00/0xFF nominal).
REQ-011 o_tx_data  out  8  packed byte to host link.
REQ-012 o_tx_valid  out  1  o_tx_data valid.
REQ-013 i_tx_ready  in  1  host link accepts byte.
REQ-014 o_busy  out  1  high in any state except IDLE.
REQ-015 o_frame_done  out  1  one-cycle pulse after last byte accepted.
REQ-016 o_short_frame  out  1  one-cycle pulse on truncated frame.

Function
REQ-017 Constants: NPIX = H_RES*V_RES; NBYTES = ceil(NPIX/8) (5100 at defaults).
REQ-018 FSM states IDLE, WAIT_VS, CAPTURE, READOUT.
REQ-019 IDLE -> WAIT_VS on i_start; i_start ignored outside IDLE.
REQ-020 Frame start = i_vsync rising edge (registered previous-value compare); WAIT_VS -> CAPTURE on it, pixel and byte counters cleared.
REQ-021 CAPTURE: each cycle with i_de=1 forms bit = (i_r_data >= BIN_TH); only first NPIX such pixels stored.
REQ-022 Packing MSB-first: first pixel of each group of 8 -> bit 7; byte written to RAM at byte counter when 8th bit arrives.
REQ-023 If NPIX mod 8 != 0, final partial byte written with unused LSBs = 0.
REQ-024 CAPTURE -> READOUT the cycle after the NPIXth pixel (and final write) is accepted; later i_de pixels ignored.
REQ-025 i_vsync rising edge in CAPTURE before NPIX pixels: o_short_frame pulses, counters clear, stay in CAPTURE as a fresh frame start.
REQ-026 READOUT: bytes 0..NBYTES-1 presented in address order; RAM read latency 1 cycle, o_tx_data registered.
REQ-027 Handshake: byte transfers when o_tx_valid && i_tx_ready; o_tx_data and o_tx_valid hold while o_tx_valid && !i_tx_ready.
REQ-028 o_tx_valid never drops without a transfer; throughput 1 byte/cycle with i_tx_ready held high (prefetch next address).
REQ-029 Transfer of byte NBYTES-1: o_tx_valid low next cycle, o_frame_done pulses 1 cycle, FSM -> IDLE.
REQ-030 i_vsync/i_de activity in IDLE, READOUT ignored; RAM not written outside CAPTURE.
REQ-031 Counters sized $clog2(NPIX+1), $clog2(NBYTES+1); no wrap permitted inside a frame.

Reset
REQ-032 rst (sync) forces state IDLE, all counters 0, vsync history 0, shift register 0.
REQ-033 Reset values: o_tx_data=0, o_tx_valid=0, o_busy=0, o_frame_done=0, o_short_frame=0.
REQ-034 rst mid-CAPTURE or mid-READOUT aborts immediately; no o_frame_done; RAM contents undefined, not cleared.

Structure
REQ-035 Package edge_cap_pkg holds state enum and helper function for NBYTES.
REQ-036 Sub-module edge_cap_ram: simple dual-port byte RAM, depth NBYTES, 1 write port, 1 registered read port, BRAM-inferable.

Verification
REQ-038 Reset: assert rst 2 cycles mid-READOUT -> next cycle o_tx_valid=0, o_busy=0, no o_frame_done.
REQ-039 Default params, start, full frame of pixels alternating 0xFF,0x00 -> 5100 bytes, each 0xAA, then o_frame_done pulse once.
REQ-040 Pixels 0x7F vs 0x80 at BIN_TH=128 -> bit 0 vs bit 1; first pixel 0x80 followed by seven 0x00 -> byte 0 = 0x80.
REQ-041 i_tx_ready toggling random 30% duty -> byte sequence identical to ready-always-high run; data stable during stalls.
REQ-042 vsync rising after 1000 pixels -> o_short_frame pulse, capture restarts; subsequent full frame reads back correctly.
REQ-043 H_RES=5, V_RES=3 (NPIX=15), all 0xFF -> 2 bytes: 0xFF, 0xFE; i_start during READOUT ignored.
